// File: rtl/nand_bist_pkg.sv
// Shared definitions for the NAND BIST tile: FSM states, LFSR/MISR taps,
// Tiny Tapeout pin indices and the shift-with-feedback helper.
package nand_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Feedback taps on bits 7,5,4,3 for both the stimulus LFSR and the MISR.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] MISR_TAPS = 8'hB8;

    localparam int unsigned UIO_STROBE = 0;
    localparam int unsigned UIO_START  = 1;
    localparam int unsigned UIO_DONE   = 2;
    localparam int unsigned UIO_PASS   = 3;
    localparam int unsigned UIO_BUSY   = 4;
    localparam int unsigned UI_MODE    = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'h1C;

    function automatic logic [7:0] shift_fb(input logic [7:0] v, input logic [7:0] taps);
        return {v[6:0], ^(v & taps)};
    endfunction

endpackage

// File: rtl/nand4_cell.sv
// Combinational 4-bit NAND under test, shared by functional and BIST modes.
// NAND_BIST_FAULT_INJECT_EN adds a stuck-at-1 point on output bit 0.
module nand4_cell (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
`ifdef NAND_BIST_FAULT_INJECT_EN
    input  logic       fault_i,
`endif
    output logic [3:0] y_o
);

`ifdef NAND_BIST_FAULT_INJECT_EN
    assign y_o = {~(a_i[3:1] & b_i[3:1]), ~(a_i[0] & b_i[0]) | fault_i};
`else
    assign y_o = ~(a_i & b_i);
`endif

endmodule

// File: rtl/tt_um_peterwilliam24_nand_bist.sv
// Tiny Tapeout NAND tile: strobed functional NAND with a transaction count, plus an
// LFSR/MISR self-test. Optional stuck-at fault point: NAND_BIST_FAULT_INJECT_EN.
module tt_um_peterwilliam24_nand_bist
    import nand_bist_pkg::*;
#(
    parameter int unsigned N_VECTORS = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] LAST_VEC = 8'(N_VECTORS - 1);

    state_e     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] misr_q, misr_d;
    logic [7:0] vec_cnt_q, vec_cnt_d;
    logic       err_q, err_d;
    logic [3:0] count_q, count_d;
    logic [3:0] result_q, result_d;
    logic       strobe_q, start_q;

    logic       mode;
    logic       strobe_rise, start_rise;
    logic [3:0] cell_a, cell_b, cell_y, cell_ref;
    logic       unused_inputs;

    assign mode        = ui_in[UI_MODE];
    assign strobe_rise = uio_in[UIO_STROBE] & ~strobe_q;
    assign start_rise  = uio_in[UIO_START] & ~start_q;
    assign unused_inputs = &{1'b0, ui_in[6:4], uio_in[3:2]};

    // The cell sees the LFSR pattern during RUN and the pin operands otherwise.
    assign cell_a   = (state_q == RUN) ? lfsr_q[3:0] : ui_in[3:0];
    assign cell_b   = (state_q == RUN) ? lfsr_q[7:4] : uio_in[7:4];
    assign cell_ref = ~(cell_a & cell_b);

    nand4_cell u_cell (
        .a_i    (cell_a),
        .b_i    (cell_b),
`ifdef NAND_BIST_FAULT_INJECT_EN
        .fault_i(ui_in[6]),
`endif
        .y_o    (cell_y)
    );

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        vec_cnt_d = vec_cnt_q;
        err_d     = err_q;
        count_d   = count_q;
        result_d  = result_q;

        if (!mode) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_rise) begin
                        state_d   = RUN;
                        lfsr_d    = SEED_EFF;
                        misr_d    = '0;
                        vec_cnt_d = '0;
                        err_d     = 1'b0;
                    end
                end
                RUN: begin
                    lfsr_d    = shift_fb(lfsr_q, LFSR_TAPS);
                    misr_d    = shift_fb(misr_q, MISR_TAPS) ^ {4'h0, cell_y};
                    err_d     = err_q | (cell_y != cell_ref);
                    vec_cnt_d = vec_cnt_q + 8'd1;
                    if (vec_cnt_q == LAST_VEC) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if ((state_q == IDLE) && !mode && strobe_rise) begin
            result_d = cell_y;
            count_d  = count_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            misr_q    <= '0;
            vec_cnt_q <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
            result_q  <= '0;
            strobe_q  <= 1'b0;
            start_q   <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            vec_cnt_q <= vec_cnt_d;
            err_q     <= err_d;
            count_q   <= count_d;
            result_q  <= result_d;
            strobe_q  <= uio_in[UIO_STROBE];
            start_q   <= uio_in[UIO_START];
        end
    end

    always_comb begin
        unique case (state_q)
            RUN:     uo_out = lfsr_q;
            DONE:    uo_out = misr_q;
            default: uo_out = {count_q, result_q};
        endcase
    end

    always_comb begin
        uio_out           = '0;
        uio_out[UIO_DONE] = (state_q == DONE);
        uio_out[UIO_PASS] = (state_q == DONE) & ~err_q;
        uio_out[UIO_BUSY] = (state_q == RUN);
    end

    assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_peterwilliam24_nand_bist.sv
// Scoreboard bench for the NAND BIST tile: stimulus pushes expected responses,
// an independent monitor pops and compares whenever the DUT presents a result.
module tb_tt_um_peterwilliam24_nand_bist;

    localparam int         N    = 16;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef NAND_BIST_FAULT_INJECT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_peterwilliam24_nand_bist #(
        .N_VECTORS(N),
        .LFSR_SEED(SEED)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] func_q[$];
    logic [8:0] bist_q[$];

    // Functional-mode model state.
    int         m_count = 0;
    logic [3:0] m_res   = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s at %0t", name, why, $time);
    endtask

    // Whole-run reference: walk the seed through N vectors and fold each NAND result in.
    function automatic logic [8:0] bist_model(input bit fault);
        logic [7:0] l;
        logic [7:0] m;
        logic [3:0] good;
        logic [3:0] y;
        bit         err;
        l   = (SEED == 8'h00) ? 8'h01 : SEED;
        m   = 8'h00;
        err = 1'b0;
        for (int i = 0; i < N; i++) begin
            good = ~(l[3:0] & l[7:4]);
            y    = good;
            if (fault) y[0] = 1'b1;
            if (y != good) err = 1'b1;
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ {4'h0, y};
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return {~err, m};
    endfunction

    // Monitor: a functional result is presented when the count changes while idle;
    // a BIST result is presented when done rises.
    initial begin : monitor
        logic       prev_idle;
        logic       prev_done;
        logic       idle;
        logic [3:0] prev_cnt;
        logic [7:0] fexp;
        logic [8:0] bexp;
        int         busy_len;
        prev_idle = 1'b0;
        prev_done = 1'b0;
        prev_cnt  = 4'h0;
        busy_len  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_idle = 1'b0;
                prev_done = 1'b0;
                busy_len  = 0;
                continue;
            end
            idle = !uio_out[4] && !uio_out[2];
            if (uio_out[4]) busy_len++;
            if (idle && prev_idle && (uo_out[7:4] != prev_cnt)) begin
                if (func_q.size() == 0) begin
                    fail_now("func_unexpected", "count changed with no strobe pending");
                end else begin
                    fexp = func_q.pop_front();
                    check("func_result", uo_out, fexp);
                end
            end
            if (uio_out[2] && !prev_done) begin
                if (bist_q.size() == 0) begin
                    fail_now("bist_unexpected", "done rose with no run pending");
                end else begin
                    bexp = bist_q.pop_front();
                    check("bist_signature", uo_out, bexp[7:0]);
                    check("bist_pass", uio_out[3], bexp[8]);
                    check("bist_busy_cycles", busy_len, N);
                end
                busy_len = 0;
            end
            if (idle) busy_len = 0;
            prev_idle = idle;
            prev_done = uio_out[2];
            prev_cnt  = uo_out[7:4];
        end
    end

    task automatic set_mode(input logic m);
        @(negedge clk);
        ui_in[7] = m;
        @(negedge clk);
    endtask

    task automatic strobe(input logic [3:0] a, input logic [3:0] b, input bit fault);
        logic [3:0] y;
        @(negedge clk);
        ui_in[3:0]  = a;
        uio_in[7:4] = b;
        ui_in[6]    = fault;
        uio_in[0]   = 1'b1;
        y = ~(a & b);
        if (fault && FAULT_EN) y[0] = 1'b1;
        m_count = (m_count + 1) % 16;
        m_res   = y;
        func_q.push_back({4'(m_count), y});
        @(negedge clk);
        uio_in[0] = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        uio_in[1] = 1'b1;
        @(negedge clk);
        uio_in[1] = 1'b0;
    endtask

    task automatic bist_run(input bit fault);
        @(negedge clk);
        ui_in[7] = 1'b1;
        ui_in[6] = fault;
        bist_q.push_back(bist_model(fault && FAULT_EN));
        start_pulse();
        for (int i = 0; i < N + 8 && !uio_out[2]; i++) @(negedge clk);
        if (!uio_out[2]) fail_now("bist_done_timeout", "done never rose");
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state.
        #12;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h1C);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed functional values, then wrap the 4-bit count.
        strobe(4'hF, 4'hF, 1'b0);
        strobe(4'h5, 4'h3, 1'b0);
        for (int i = 0; i < 14; i++) strobe(4'($urandom), 4'($urandom), 1'b0);
        @(negedge clk);
        check("count_wrap", uo_out[7:4], 4'h0);

        // Held strobe: one rise, then no further increments while operands change.
        strobe_hold: begin
            logic [3:0] y;
            @(negedge clk);
            ui_in[3:0]  = 4'hA;
            uio_in[7:4] = 4'hC;
            uio_in[0]   = 1'b1;
            y = ~(4'hA & 4'hC);
            m_count = (m_count + 1) % 16;
            m_res   = y;
            func_q.push_back({4'(m_count), y});
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                ui_in[3:0]  = 4'($urandom);
                uio_in[7:4] = 4'($urandom);
            end
            check("held_strobe", uo_out, {4'(m_count), m_res});
            uio_in[0] = 1'b0;
        end

        // Tile disabled: a full strobe pulse must leave everything untouched.
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ui_in[3:0]  = 4'h0;
        uio_in[7:4] = 4'h0;
        uio_in[0]   = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        check("ena_low_hold", uo_out, {4'(m_count), m_res});

        // Randomized functional traffic with random gaps and fault-request bit.
        for (int i = 0; i < 20; i++) begin
            strobe(4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        ui_in[6] = 1'b0;

        // Clean BIST twice; second run starts from DONE and must match.
        bist_run(1'b0);
        bist_run(1'b0);

        // Abort on the fifth RUN cycle.
        start_pulse();
        for (int i = 0; i < 4 && !uio_out[4]; i++) @(negedge clk);
        if (!uio_out[4]) fail_now("abort_busy_timeout", "busy never rose");
        check("run_lfsr_seed", uo_out, SEED);
        repeat (4) @(negedge clk);
        ui_in[7] = 1'b0;
        @(negedge clk);
        check("abort_busy", uio_out[4], 1'b0);
        check("abort_done", uio_out[2], 1'b0);
        check("abort_restore", uo_out, {4'(m_count), m_res});

        strobe(4'h6, 4'h3, 1'b0);

        // Fault request during BIST and functional mode.
        bist_run(1'b1);
        set_mode(1'b0);
        strobe(4'h0, 4'h0, 1'b1);
        strobe(4'hF, 4'hF, 1'b1);
        ui_in[6] = 1'b0;

        // Asynchronous reset in the middle of a run, applied off the clock edge.
        set_mode(1'b1);
        start_pulse();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo_out", uo_out, 8'h00);
        check("async_rst_uio_out", uio_out, 8'h00);
        check("async_rst_uio_oe", uio_oe, 8'h1C);
        m_count = 0;
        m_res   = 4'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_mode(1'b0);
        repeat (2) @(negedge clk);
        strobe(4'h9, 4'h9, 1'b0);

        repeat (4) @(negedge clk);
        check("func_queue_drained", func_q.size(), 0);
        check("bist_queue_drained", bist_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
